// File: rtl/var_delay_line.sv
// Runtime-programmable delay line for a valid-tagged N-bit stream, built on a circular history buffer.
// Define VAR_DELAY_FLUSH_EN to clear the history whenever a load changes the active delay.
module var_delay_line #(
  parameter int N = 1,
  parameter int MAX_DELAY = 16,
  parameter int INIT_DELAY = 1,
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  idata,
  input  logic          ivalid,
  input  logic [DW-1:0] delay,
  input  logic          delay_load,
  output logic [N-1:0]  odata,
  output logic          ovalid,
  output logic [DW-1:0] delay_cur
);

  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DELAY);
  localparam logic [DW-1:0] INIT_D = DW'(INIT_DELAY);
  localparam logic [DW:0]   MAX_E  = (DW + 1)'(MAX_DELAY);
  localparam logic [AW-1:0] WP_LAST = AW'(MAX_DELAY - 1);

  logic [N-1:0]         mem [MAX_DELAY];
  logic [MAX_DELAY-1:0] valid_reg;
  logic [MAX_DELAY-1:0] valid_next;
  logic [AW-1:0]        wp_reg;
  logic [DW-1:0]        d_reg;
  logic [DW-1:0]        d_next;
  logic                 flush;
  logic [DW:0]          rd_sum;
  logic [DW:0]          rd_idx_e;
  logic [AW-1:0]        rd_idx;
  logic                 unused_rd_bits;

  assign d_next = (delay > MAX_D) ? MAX_D : delay;

`ifdef VAR_DELAY_FLUSH_EN
  assign flush = delay_load && (d_next != d_reg);
`else
  assign flush = 1'b0;
`endif

  // The slot being written always takes the new sample, even in a flush cycle.
  generate
    for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_valid
      assign valid_next[gi] = (wp_reg == AW'(gi)) ? ivalid :
                              flush               ? 1'b0   : valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg    <= '0;
      d_reg     <= INIT_D;
      valid_reg <= '0;
    end else begin
      wp_reg    <= (wp_reg == WP_LAST) ? '0 : wp_reg + 1'b1;
      valid_reg <= valid_next;
      if (delay_load) begin
        d_reg <= d_next;
      end
    end
  end

  // Data bits carry no reset; stale contents are hidden by the valid mask.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[wp_reg] <= idata;
    end
  end

  // (wp - D) mod MAX_DELAY as wp + (MAX_DELAY - D), folded once; never underflows.
  assign rd_sum         = (DW + 1)'(wp_reg) + (MAX_E - {1'b0, d_reg});
  assign rd_idx_e       = (rd_sum >= MAX_E) ? (rd_sum - MAX_E) : rd_sum;
  assign rd_idx         = rd_idx_e[AW-1:0];
  assign unused_rd_bits = ^rd_idx_e[DW:AW];

  always_comb begin
    ovalid = 1'b0;
    odata  = '0;
    if (d_reg == '0) begin
      ovalid = ivalid;
      odata  = ivalid ? idata : '0;
    end else begin
      ovalid = valid_reg[rd_idx];
      odata  = valid_reg[rd_idx] ? mem[rd_idx] : '0;
    end
  end

  assign delay_cur = d_reg;

endmodule
